// File: rtl/axi_master_pkg.sv
// ---------------------------------------------------------------------------
// axi_master_pkg
// Shared definitions for the simple single-beat AXI master:
//   - AXI response codes
//   - host request (rw) encodings
//   - FSM state constants (plain localparams so legacy code can use them)
//   - request_legal(): checks a host request for legality (rw code, size
//     range and natural alignment)
// ---------------------------------------------------------------------------
package axi_master_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [1:0] {
      RW_IDLE    = 2'b00,
      RW_WRITE   = 2'b01,
      RW_READ    = 2'b10,
      RW_ILLEGAL = 2'b11
   } host_rw_e;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_AW   = 3'd1;
   localparam logic [2:0] ST_W    = 3'd2;
   localparam logic [2:0] ST_B    = 3'd3;
   localparam logic [2:0] ST_AR   = 3'd4;
   localparam logic [2:0] ST_R    = 3'd5;
   localparam logic [2:0] ST_HOLD = 3'd6;

   // A request is legal when its rw code is write or read, its size is at
   // most a dword, and its address is naturally aligned to that size.
   function automatic logic request_legal(input logic [1:0] rw,
                                          input logic [2:0] size,
                                          input logic [2:0] addr_lsb);
      logic [2:0] mask;
      case (size)
         3'd0:    mask = 3'b000;
         3'd1:    mask = 3'b001;
         3'd2:    mask = 3'b011;
         3'd3:    mask = 3'b111;
         default: mask = 3'b000;
      endcase
      return (rw != RW_ILLEGAL) && !size[2] && ((addr_lsb & mask) == 3'b000);
   endfunction

endpackage

// File: rtl/axi_lane_align.sv
// ---------------------------------------------------------------------------
// axi_lane_align
// Combinational byte-lane steering between the right-justified host data
// and the 64-bit AXI data bus.
// Ports:
//   addr_lsb   in   3   byte offset of the access within the 64-bit word
//   size       in   2   log2 of access size in bytes (0..3)
//   wdata_in   in  64   right-justified host write data
//   wdata_out  out 64   write data moved onto its byte lanes
//   wstrb      out  8   byte strobes for the access
//   rdata_in   in  64   raw AXI read data
//   rdata_out  out 64   read data right-justified and zero-extended
// ---------------------------------------------------------------------------
module axi_lane_align (
   input  logic [2:0]  addr_lsb,
   input  logic [1:0]  size,
   input  logic [63:0] wdata_in,
   output logic [63:0] wdata_out,
   output logic [7:0]  wstrb,
   input  logic [63:0] rdata_in,
   output logic [63:0] rdata_out
);

   logic [7:0]  byte_mask;
   logic [63:0] bit_mask;
   logic [63:0] rdata_shifted;
   logic [5:0]  bit_shift;

   assign bit_shift = {addr_lsb, 3'b000};

   // Byte mask of the access as if it started at lane 0; shifted into place
   // for the strobes and expanded to a bit mask for read extraction.
   always_comb begin
      byte_mask = 8'h00;
      case (size)
         2'd0: byte_mask = 8'h01;
         2'd1: byte_mask = 8'h03;
         2'd2: byte_mask = 8'h0F;
         2'd3: byte_mask = 8'hFF;
         default: byte_mask = 8'h00;
      endcase
      bit_mask = '0;
      for (int i = 0; i < 8; i++) begin
         bit_mask[8*i +: 8] = {8{byte_mask[i]}};
      end
   end

   assign wstrb         = byte_mask << addr_lsb;
   assign wdata_out     = wdata_in << bit_shift;
   assign rdata_shifted = rdata_in >> bit_shift;
   assign rdata_out     = rdata_shifted & bit_mask;

endmodule

// File: rtl/simple_axi_master.sv
// ---------------------------------------------------------------------------
// simple_axi_master
// Single-beat AXI4 master: turns one host request (addr/size/rw) into one
// AXI write (AW -> W -> B) or read (AR -> R) and reports sticky status.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   i_addr/i_size      byte address and log2 size of the access
//   i_wdata/o_rdata    right-justified write / read data
//   i_rw               00 idle, 01 write, 10 read, 11 illegal
//   o_wait             transaction in progress
//   o_done/o_error/o_invalid   sticky status, cleared by i_clear or a new request
//   m_axi_aw*/w*/b*/ar*/r*     AXI4 master channels (single beat)
//   o_debug_latency    busy cycles of the last transaction
// ---------------------------------------------------------------------------
module simple_axi_master
   import axi_master_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [2:0]        i_size,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata,
   input  logic [1:0]        i_rw,
   output logic              o_wait,
   output logic              o_done,
   input  logic              i_clear,
   output logic              o_invalid,
   output logic              o_error,
   output logic              m_axi_awvalid,
   input  logic              m_axi_awready,
   output logic [ADDR_W-1:0] m_axi_awaddr,
   output logic [2:0]        m_axi_awsize,
   output logic              m_axi_wvalid,
   input  logic              m_axi_wready,
   output logic              m_axi_wlast,
   output logic [DATA_W-1:0] m_axi_wdata,
   output logic [7:0]        m_axi_wstrb,
   input  logic              m_axi_bvalid,
   output logic              m_axi_bready,
   input  logic [1:0]        m_axi_bresp,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic [2:0]        m_axi_arsize,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready,
   input  logic              m_axi_rlast,
   input  logic [DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   output logic [31:0]       o_debug_latency
);

   logic [2:0]        state;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic [DATA_W-1:0] wdata_q;
   logic [31:0]       lat_cnt;
   logic [31:0]       lat_next;
   logic [63:0]       rdata_aligned;
   logic              unused;

   // Single-beat reads always carry rlast; it carries no information here.
   assign unused = m_axi_rlast;

   axi_lane_align u_align (
      .addr_lsb  (addr_q[2:0]),
      .size      (size_q),
      .wdata_in  (wdata_q),
      .wdata_out (m_axi_wdata),
      .wstrb     (m_axi_wstrb),
      .rdata_in  (m_axi_rdata),
      .rdata_out (rdata_aligned)
   );

   // Channel handshakes are decoded straight from the state so that a reset
   // drops every valid/ready on the following edge.
   assign m_axi_awvalid = (state == ST_AW);
   assign m_axi_wvalid  = (state == ST_W);
   assign m_axi_wlast   = (state == ST_W);
   assign m_axi_bready  = (state == ST_B);
   assign m_axi_arvalid = (state == ST_AR);
   assign m_axi_rready  = (state == ST_R);
   assign m_axi_awaddr  = addr_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_awsize  = {1'b0, size_q};
   assign m_axi_arsize  = {1'b0, size_q};
   assign o_wait        = (state == ST_AW) || (state == ST_W) || (state == ST_B) ||
                          (state == ST_AR) || (state == ST_R);

   // Saturating increment; the completing cycle itself counts as busy.
   assign lat_next = (lat_cnt == 32'hFFFF_FFFF) ? lat_cnt : lat_cnt + 32'd1;

   // FSM, request latch, latency counter and sticky status. i_clear is
   // applied first so that a status set on the same edge overrides it.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state           <= ST_IDLE;
         addr_q          <= '0;
         size_q          <= '0;
         wdata_q         <= '0;
         lat_cnt         <= '0;
         o_debug_latency <= '0;
         o_rdata         <= '0;
         o_done          <= 1'b0;
         o_error         <= 1'b0;
         o_invalid       <= 1'b0;
      end else begin
         if (i_clear) begin
            o_done    <= 1'b0;
            o_error   <= 1'b0;
            o_invalid <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (i_rw != RW_IDLE) begin
                  addr_q  <= i_addr;
                  size_q  <= i_size[1:0];
                  wdata_q <= i_wdata;
                  lat_cnt <= '0;
                  if (!request_legal(i_rw, i_size, i_addr[2:0])) begin
                     o_done          <= 1'b1;
                     o_error         <= 1'b1;
                     o_invalid       <= 1'b1;
                     o_debug_latency <= '0;
                     state           <= ST_HOLD;
                  end else begin
                     o_done    <= 1'b0;
                     o_error   <= 1'b0;
                     o_invalid <= 1'b0;
                     state     <= (i_rw == RW_WRITE) ? ST_AW : ST_AR;
                  end
               end
            end
            ST_AW: begin
               lat_cnt <= lat_next;
               if (m_axi_awready) state <= ST_W;
            end
            ST_W: begin
               lat_cnt <= lat_next;
               if (m_axi_wready) state <= ST_B;
            end
            ST_B: begin
               lat_cnt <= lat_next;
               if (m_axi_bvalid) begin
                  state           <= ST_HOLD;
                  o_debug_latency <= lat_next;
                  o_done          <= 1'b1;
                  o_error         <= m_axi_bresp[1];
                  o_invalid       <= (m_axi_bresp == RESP_DECERR);
               end
            end
            ST_AR: begin
               lat_cnt <= lat_next;
               if (m_axi_arready) state <= ST_R;
            end
            ST_R: begin
               lat_cnt <= lat_next;
               if (m_axi_rvalid) begin
                  state           <= ST_HOLD;
                  o_debug_latency <= lat_next;
                  o_done          <= 1'b1;
                  o_error         <= m_axi_rresp[1];
                  o_invalid       <= (m_axi_rresp == RESP_DECERR);
                  o_rdata         <= m_axi_rresp[1] ? '0 : rdata_aligned;
               end
            end
            ST_HOLD: begin
               if (i_rw == RW_IDLE) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_simple_axi_master.sv
// ---------------------------------------------------------------------------
// tb_simple_axi_master
// Drives host requests into simple_axi_master against a small byte-addressed
// AXI slave with programmable per-channel delay and response code. Expected
// results are queued when a request is driven and compared on completion.
// ---------------------------------------------------------------------------
module tb_simple_axi_master;

   logic        clk;
   logic        rstn;
   logic [31:0] i_addr;
   logic [2:0]  i_size;
   logic [63:0] i_wdata;
   logic [63:0] o_rdata;
   logic [1:0]  i_rw;
   logic        o_wait;
   logic        o_done;
   logic        i_clear;
   logic        o_invalid;
   logic        o_error;
   logic        m_axi_awvalid, m_axi_awready;
   logic [31:0] m_axi_awaddr;
   logic [2:0]  m_axi_awsize;
   logic        m_axi_wvalid, m_axi_wready, m_axi_wlast;
   logic [63:0] m_axi_wdata;
   logic [7:0]  m_axi_wstrb;
   logic        m_axi_bvalid, m_axi_bready;
   logic [1:0]  m_axi_bresp;
   logic        m_axi_arvalid, m_axi_arready;
   logic [31:0] m_axi_araddr;
   logic [2:0]  m_axi_arsize;
   logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;
   logic [63:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic [31:0] o_debug_latency;

   simple_axi_master dut (
      .clk             (clk),
      .rstn            (rstn),
      .i_addr          (i_addr),
      .i_size          (i_size),
      .i_wdata         (i_wdata),
      .o_rdata         (o_rdata),
      .i_rw            (i_rw),
      .o_wait          (o_wait),
      .o_done          (o_done),
      .i_clear         (i_clear),
      .o_invalid       (o_invalid),
      .o_error         (o_error),
      .m_axi_awvalid   (m_axi_awvalid),
      .m_axi_awready   (m_axi_awready),
      .m_axi_awaddr    (m_axi_awaddr),
      .m_axi_awsize    (m_axi_awsize),
      .m_axi_wvalid    (m_axi_wvalid),
      .m_axi_wready    (m_axi_wready),
      .m_axi_wlast     (m_axi_wlast),
      .m_axi_wdata     (m_axi_wdata),
      .m_axi_wstrb     (m_axi_wstrb),
      .m_axi_bvalid    (m_axi_bvalid),
      .m_axi_bready    (m_axi_bready),
      .m_axi_bresp     (m_axi_bresp),
      .m_axi_arvalid   (m_axi_arvalid),
      .m_axi_arready   (m_axi_arready),
      .m_axi_araddr    (m_axi_araddr),
      .m_axi_arsize    (m_axi_arsize),
      .m_axi_rvalid    (m_axi_rvalid),
      .m_axi_rready    (m_axi_rready),
      .m_axi_rlast     (m_axi_rlast),
      .m_axi_rdata     (m_axi_rdata),
      .m_axi_rresp     (m_axi_rresp),
      .o_debug_latency (o_debug_latency)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave configuration and state
   int          dly_cfg;
   logic [1:0]  resp_cfg;
   logic        mem_init;
   logic [7:0]  mem [0:127];
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   logic [31:0] aw_addr_q, ar_addr_q;
   logic [7:0]  last_strb;
   logic [63:0] last_wdata;
   int          activity;

   // Reference model state
   logic [7:0]  ref_mem [0:127];
   logic [63:0] rdata_model;

   typedef struct {
      logic        is_write;
      logic        legal;
      logic [63:0] rdata;
      logic        err;
      logic        inv;
      logic [31:0] lat;
      logic [7:0]  strb;
      logic [63:0] lane_data;
   } exp_t;
   exp_t sb[$];

   int total;
   int bad;

   // Each channel's ready/valid rises after dly_cfg cycles of the master
   // asserting its side of the handshake.
   assign m_axi_awready = m_axi_awvalid && (aw_cnt == dly_cfg);
   assign m_axi_wready  = m_axi_wvalid  && (w_cnt  == dly_cfg);
   assign m_axi_bvalid  = m_axi_bready  && (b_cnt  == dly_cfg);
   assign m_axi_arready = m_axi_arvalid && (ar_cnt == dly_cfg);
   assign m_axi_rvalid  = m_axi_rready  && (r_cnt  == dly_cfg);
   assign m_axi_bresp   = resp_cfg;
   assign m_axi_rresp   = resp_cfg;
   assign m_axi_rlast   = m_axi_rvalid;

   always_comb begin
      m_axi_rdata = '0;
      for (int i = 0; i < 8; i++) begin
         m_axi_rdata[8*i +: 8] = mem[int'(ar_addr_q[6:3]) * 8 + i];
      end
   end

   always @(posedge clk) begin
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid  && !m_axi_wready)  ? w_cnt  + 1 : 0;
      b_cnt  <= (m_axi_bready  && !m_axi_bvalid)  ? b_cnt  + 1 : 0;
      ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
      r_cnt  <= (m_axi_rready  && !m_axi_rvalid)  ? r_cnt  + 1 : 0;
      if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) activity <= activity + 1;
      if (m_axi_awvalid && m_axi_awready) aw_addr_q <= m_axi_awaddr;
      if (m_axi_arvalid && m_axi_arready) ar_addr_q <= m_axi_araddr;
      if (mem_init) begin
         for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
      end else if (m_axi_wvalid && m_axi_wready) begin
         last_strb  <= m_axi_wstrb;
         last_wdata <= m_axi_wdata;
         for (int i = 0; i < 8; i++) begin
            if (m_axi_wstrb[i]) mem[int'(aw_addr_q[6:3]) * 8 + i] <= m_axi_wdata[8*i +: 8];
         end
      end
   end

   task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Builds the expectation for one request, drives it, waits for completion
   // and compares everything against the popped expectation.
   task automatic apply_stimulus(input logic [1:0] rw, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [63:0] wdata,
                                 input int dly, input logic [1:0] resp);
      exp_t e;
      int   nbytes;
      int   act_start;
      int   cycles;
      e.legal = (rw != 2'b11) && (size <= 3);
      nbytes  = (size <= 3) ? (1 << size) : 1;
      if (e.legal) e.legal = ((addr % nbytes) == 0);
      e.is_write  = (rw == 2'b01);
      e.err       = !e.legal || resp[1];
      e.inv       = !e.legal || (resp == 2'b11);
      e.lat       = !e.legal ? 32'd0 : (e.is_write ? 32'(3 * (dly + 1)) : 32'(2 * (dly + 1)));
      e.strb      = '0;
      e.lane_data = '0;
      for (int i = 0; i < nbytes; i++) begin
         e.strb[(addr % 8) + i] = 1'b1;
         e.lane_data[8*((addr % 8) + i) +: 8] = wdata[8*i +: 8];
      end
      if (e.legal && !e.is_write) begin
         if (resp[1]) rdata_model = '0;
         else begin
            rdata_model = '0;
            for (int i = 0; i < nbytes; i++) rdata_model[8*i +: 8] = ref_mem[(addr + i) % 128];
         end
      end
      if (e.legal && e.is_write) begin
         for (int i = 0; i < nbytes; i++) ref_mem[(addr + i) % 128] = wdata[8*i +: 8];
      end
      e.rdata = rdata_model;
      sb.push_back(e);

      dly_cfg   = dly;
      resp_cfg  = resp;
      act_start = activity;
      @(negedge clk);
      i_addr  = addr;
      i_size  = size;
      i_wdata = wdata;
      i_rw    = rw;
      @(negedge clk);
      if (e.legal) check_output("wait_busy", {63'd0, o_wait}, 64'd1);
      cycles = 0;
      while (!o_done && cycles < 500) begin
         @(negedge clk);
         cycles++;
      end
      if (!o_done) check_output("timeout", {63'd0, o_done}, 64'd1);

      e = sb.pop_front();
      check_output("done",    {63'd0, o_done},    64'd1);
      check_output("wait_lo", {63'd0, o_wait},    64'd0);
      check_output("error",   {63'd0, o_error},   {63'd0, e.err});
      check_output("invalid", {63'd0, o_invalid}, {63'd0, e.inv});
      check_output("latency", {32'd0, o_debug_latency}, {32'd0, e.lat});
      check_output("rdata",   o_rdata, e.rdata);
      if (!e.legal) check_output("no_axi", 64'(activity - act_start), 64'd0);
      if (e.legal && e.is_write) begin
         check_output("wstrb", {56'd0, last_strb}, {56'd0, e.strb});
         for (int i = 0; i < 8; i++) begin
            if (e.strb[i]) check_output("wlane", {56'd0, last_wdata[8*i +: 8]}, {56'd0, e.lane_data[8*i +: 8]});
         end
      end
      i_rw = 2'b00;
      @(negedge clk);
      check_output("done_hold", {63'd0, o_done}, 64'd1);
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      activity    = 0;
      dly_cfg     = 0;
      resp_cfg    = 2'b00;
      rdata_model = '0;
      aw_addr_q   = '0;
      ar_addr_q   = '0;
      last_strb   = '0;
      last_wdata  = '0;
      for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
      rstn     = 1'b0;
      mem_init = 1'b1;
      i_addr   = '0;
      i_size   = '0;
      i_wdata  = '0;
      i_rw     = 2'b00;
      i_clear  = 1'b0;
      repeat (3) @(negedge clk);
      check_output("rst_wait",    {63'd0, o_wait},    64'd0);
      check_output("rst_done",    {63'd0, o_done},    64'd0);
      check_output("rst_error",   {63'd0, o_error},   64'd0);
      check_output("rst_invalid", {63'd0, o_invalid}, 64'd0);
      check_output("rst_rdata",   o_rdata,            64'd0);
      check_output("rst_latency", {32'd0, o_debug_latency}, 64'd0);
      check_output("rst_valids",  {61'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 64'd0);
      rstn     = 1'b1;
      mem_init = 1'b0;
      @(negedge clk);

      // Aligned writes and reads
      apply_stimulus(2'b01, 32'h00, 3'd0, 64'hEE, 0, 2'b00);
      check_output("strb_byte", {56'd0, last_strb}, 64'h01);
      apply_stimulus(2'b01, 32'h02, 3'd1, 64'hABCD, 0, 2'b00);
      check_output("strb_half", {56'd0, last_strb}, 64'h0C);
      apply_stimulus(2'b01, 32'h04, 3'd2, 64'h12345678, 0, 2'b00);
      check_output("strb_word", {56'd0, last_strb}, 64'hF0);
      apply_stimulus(2'b01, 32'h08, 3'd3, 64'h11DD11DD22EE22EE, 0, 2'b00);
      check_output("strb_dword", {56'd0, last_strb}, 64'hFF);
      apply_stimulus(2'b10, 32'h00, 3'd0, 64'd0, 0, 2'b00);
      check_output("rd_byte", o_rdata, 64'hEE);
      apply_stimulus(2'b10, 32'h02, 3'd1, 64'd0, 0, 2'b00);
      check_output("rd_half", o_rdata, 64'hABCD);
      apply_stimulus(2'b10, 32'h04, 3'd2, 64'd0, 0, 2'b00);
      check_output("rd_word", o_rdata, 64'h12345678);
      apply_stimulus(2'b10, 32'h08, 3'd3, 64'd0, 0, 2'b00);
      check_output("rd_dword", o_rdata, 64'h11DD11DD22EE22EE);

      // Slow slave on every channel
      apply_stimulus(2'b01, 32'h10, 3'd2, 64'hCAFEF00D, 3, 2'b00);
      apply_stimulus(2'b10, 32'h10, 3'd2, 64'd0, 5, 2'b00);
      check_output("rd_slow", o_rdata, 64'hCAFEF00D);
      apply_stimulus(2'b01, 32'h18, 3'd3, 64'h0123456789ABCDEF, 7, 2'b01);
      apply_stimulus(2'b10, 32'h1C, 3'd2, 64'd0, 7, 2'b00);
      check_output("rd_slow_hi", o_rdata, 64'h01234567);

      // Misaligned and illegal requests
      apply_stimulus(2'b01, 32'h01, 3'd1, 64'h5555, 0, 2'b00);
      apply_stimulus(2'b01, 32'h02, 3'd2, 64'h66666666, 0, 2'b00);
      apply_stimulus(2'b01, 32'h04, 3'd3, 64'h7777777777777777, 0, 2'b00);
      apply_stimulus(2'b11, 32'h00, 3'd0, 64'h0, 0, 2'b00);
      apply_stimulus(2'b01, 32'h00, 3'd4, 64'h0, 0, 2'b00);
      apply_stimulus(2'b10, 32'h03, 3'd2, 64'd0, 0, 2'b00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_output("inv_persist", {62'd0, o_invalid, o_error}, 64'd3);
      end
      i_clear = 1'b1;
      @(negedge clk);
      i_clear = 1'b0;
      check_output("cleared", {61'd0, o_done, o_error, o_invalid}, 64'd0);
      apply_stimulus(2'b10, 32'h00, 3'd3, 64'd0, 0, 2'b00);
      check_output("mem_unchanged", o_rdata, 64'h12345678ABCD00EE);

      // Slave error responses
      apply_stimulus(2'b01, 32'h60, 3'd2, 64'h1, 0, 2'b10);
      apply_stimulus(2'b01, 32'h68, 3'd2, 64'h2, 1, 2'b11);
      apply_stimulus(2'b10, 32'h00, 3'd3, 64'd0, 0, 2'b10);
      check_output("rd_slverr", o_rdata, 64'd0);
      apply_stimulus(2'b10, 32'h00, 3'd3, 64'd0, 2, 2'b11);
      check_output("rd_decerr", o_rdata, 64'd0);

      // Requests straight out of HOLD without clearing, back-to-back bytes
      apply_stimulus(2'b01, 32'h38, 3'd2, 64'hABCDEFAB, 0, 2'b00);
      apply_stimulus(2'b01, 32'h40, 3'd0, 64'hFF, 0, 2'b00);
      apply_stimulus(2'b01, 32'h41, 3'd0, 64'hEE, 0, 2'b00);
      apply_stimulus(2'b10, 32'h40, 3'd1, 64'd0, 0, 2'b00);
      check_output("rd_eeff", o_rdata, 64'hEEFF);
      apply_stimulus(2'b10, 32'h38, 3'd2, 64'd0, 1, 2'b00);
      check_output("rd_38", o_rdata, 64'hABCDEFAB);

      // Reset in the middle of a write aborts it
      dly_cfg = 5;
      @(negedge clk);
      i_addr = 32'h20;
      i_size = 3'd2;
      i_rw   = 2'b01;
      repeat (2) @(negedge clk);
      check_output("mid_busy", {63'd0, m_axi_awvalid}, 64'd1);
      rstn = 1'b0;
      i_rw = 2'b00;
      @(negedge clk);
      check_output("mid_rst", {59'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, o_wait, o_done}, 64'd0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      check_output("mid_idle", {63'd0, o_wait}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
